// File: rtl/fetch_unit_rv32i_if.sv
// fetch_unit_rv32i_if: bundle of signals between the RV32I fetch stage, instruction memory and execute
// Signals:
//   imem_req/imem_addr         fetch request and address (fetch -> memory)
//   imem_ack/imem_rdata        response strobe and instruction word (memory -> fetch)
//   instr_valid/instr          captured instruction (fetch -> execute)
//   opcode/funct3/funct7       decode fields of instr (fetch -> control unit)
//   instr_pc/pc_plus4          PC of instr and its sequential successor (fetch -> datapath)
//   ex_done/redirect_en/pc     completion and optional redirect target (execute -> fetch)
//   fault                      sticky fetch fault (fetch -> system)
// Modports: master = fetch unit view, slave = memory/execute environment view.
interface fetch_unit_rv32i_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        ex_done;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        fault;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, funct3, funct7,
               instr_pc, pc_plus4, fault,
        input  imem_ack, imem_rdata, ex_done, redirect_en, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, funct3, funct7,
               instr_pc, pc_plus4, fault,
        output imem_ack, imem_rdata, ex_done, redirect_en, redirect_pc
    );
endinterface

// File: rtl/fetch_unit_rv32i.sv
// fetch_unit_rv32i: RV32I fetch stage holding the PC, fetching over req/ack and holding the instruction for execute
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fetch_unit_rv32i_if.master: imem req/addr/ack/rdata, instr + opcode/funct3/funct7,
//          instr_pc/pc_plus4, ex_done/redirect_en/redirect_pc from execute, sticky fault
// Parameters:
//   RESET_PC       PC loaded on reset
//   FETCH_TIMEOUT  unacknowledged FETCH cycles (1..255) before entering FAULT
// Optional feature macro: IFETCH_MISALIGN_CHK_EN -- when defined, a retiring redirect to a target with
// nonzero [1:0] enters FAULT; otherwise the low two target bits are cleared when loaded into the PC.
module fetch_unit_rv32i #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input logic clk,
    input logic rst_n,
    fetch_unit_rv32i_if.master bus
);
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [7:0]  TMO_LAST = 8'(FETCH_TIMEOUT - 1);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        fetch_ack, timeout, retire, misalign;
    logic [31:0] target;

    assign fetch_ack = state_q == S_FETCH && bus.imem_ack;
    // An ack in the last allowed cycle takes priority over the timeout.
    assign timeout   = state_q == S_FETCH && !bus.imem_ack && cnt_q == TMO_LAST;
    assign retire    = state_q == S_HOLD && bus.ex_done;
    assign target    = bus.redirect_en ? (bus.redirect_pc & ~32'h3) : pc_q + 32'd4;

`ifdef IFETCH_MISALIGN_CHK_EN
    assign misalign = bus.redirect_en && bus.redirect_pc[1:0] != 2'b00;
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (fetch_ack) state_d = S_HOLD;
        else if (timeout) state_d = S_FAULT;
        else if (retire) state_d = misalign ? S_FAULT : S_FETCH;
    end

    always_comb begin
        bus.imem_req = state_q == S_FETCH;
        bus.fault    = state_q == S_FAULT;
    end

    // Retiring always clears the held instruction, including a misaligned redirect into FAULT.
    always_comb begin
        pc_d       = (retire && !misalign) ? target : pc_q;
        instr_d    = fetch_ack ? bus.imem_rdata : retire ? NOP : instr_q;
        instr_pc_d = fetch_ack ? pc_q : instr_pc_q;
        valid_d    = fetch_ack | (valid_q & ~retire);
        cnt_d      = fetch_ack ? 8'd0 : (state_q == S_FETCH && !timeout) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP;
            instr_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[6:0];
    assign bus.funct3      = instr_q[14:12];
    assign bus.funct7      = instr_q[31:25];
    assign bus.instr_pc    = instr_pc_q;
    assign bus.pc_plus4    = instr_pc_q + 32'd4;
endmodule
